// File: rtl/pulse_sched_if.sv
// Requester-side bundle for pulse_sched: level requests and burst counts in,
// grant/done/busy status and the shared pulse train out.
interface pulse_sched_if #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned CNT_W = 8
) ();
   logic [NREQ-1:0]       i_req;
   logic [NREQ*CNT_W-1:0] i_count;
   logic [NREQ-1:0]       o_grant;
   logic [NREQ-1:0]       o_done;
   logic                  o_busy;
   logic                  o_pulse;

   modport master (
      output i_req, i_count,
      input  o_grant, o_done, o_busy, o_pulse
   );

   modport slave (
      input  i_req, i_count,
      output o_grant, o_done, o_busy, o_pulse
   );
endinterface

// File: rtl/pulse_sched.sv
// Round-robin, non-preemptive scheduler sharing one pulse-train output between
// NREQ requesters; each grant produces a burst of i_count pulses then a done strobe.
module pulse_sched #(
   parameter int unsigned NREQ     = 4,
   parameter int unsigned CNT_W    = 8,
   parameter int unsigned HIGH_CYC = 4,
   parameter int unsigned LOW_CYC  = 4
) (
   input logic          i_clk,
   input logic          i_rst_n,
   pulse_sched_if.slave bus_io
);
   localparam int unsigned IdxW   = $clog2(NREQ);
   localparam int unsigned MaxCyc = (HIGH_CYC > LOW_CYC) ? HIGH_CYC : LOW_CYC;
   localparam int unsigned TimerW = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

   typedef enum logic [1:0] {StIdle, StHigh, StLow, StDone} state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  remaining_q, remaining_d;
   logic [TimerW-1:0] timer_q, timer_d;
   logic [IdxW-1:0]   last_q, last_d;
   logic [NREQ-1:0]   grant_q, grant_d;
   logic [NREQ-1:0]   done_q, done_d;
   logic              busy_q, busy_d;
   logic              pulse_q, pulse_d;

   logic              found;
   logic [IdxW-1:0]   winner;
   logic [IdxW-1:0]   cand;
   logic [NREQ-1:0]   win_onehot;
   logic [CNT_W-1:0]  win_count;

   // Search starts one past the last winner so every pending requester is served in turn.
   always_comb begin
      found  = 1'b0;
      winner = last_q;
      cand   = '0;
      for (int unsigned i = 1; i <= NREQ; i++) begin
         cand = IdxW'((32'(last_q) + i) % NREQ);
         if (!found && bus_io.i_req[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
      win_onehot = NREQ'(1) << winner;
      win_count  = bus_io.i_count[winner*CNT_W +: CNT_W];
   end

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      timer_d     = timer_q;
      last_d      = last_q;
      grant_d     = grant_q;
      done_d      = '0;
      pulse_d     = 1'b0;
      unique case (state_q)
         StIdle: begin
            grant_d = '0;
            if (found) begin
               last_d      = winner;
               grant_d     = win_onehot;
               remaining_d = win_count;
               if (win_count != '0) begin
                  state_d = StHigh;
                  timer_d = TimerW'(HIGH_CYC - 1);
                  pulse_d = 1'b1;
               end else begin
                  state_d = StDone;
                  timer_d = '0;
                  done_d  = win_onehot;
               end
            end
         end
         StHigh: begin
            if (timer_q == '0) begin
               remaining_d = remaining_q - CNT_W'(1);
               if (remaining_q == CNT_W'(1)) begin
                  state_d = StDone;
                  timer_d = '0;
                  done_d  = grant_q;
               end else begin
                  state_d = StLow;
                  timer_d = TimerW'(LOW_CYC - 1);
               end
            end else begin
               timer_d = timer_q - TimerW'(1);
               pulse_d = 1'b1;
            end
         end
         StLow: begin
            if (timer_q == '0) begin
               state_d = StHigh;
               timer_d = TimerW'(HIGH_CYC - 1);
               pulse_d = 1'b1;
            end else begin
               timer_d = timer_q - TimerW'(1);
            end
         end
         StDone: begin
            state_d = StIdle;
            timer_d = '0;
            grant_d = '0;
         end
         default: state_d = StIdle;
      endcase
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q     <= StIdle;
         remaining_q <= '0;
         timer_q     <= '0;
         last_q      <= IdxW'(NREQ - 1);
         grant_q     <= '0;
         done_q      <= '0;
         busy_q      <= 1'b0;
         pulse_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         timer_q     <= timer_d;
         last_q      <= last_d;
         grant_q     <= grant_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
         pulse_q     <= pulse_d;
      end
   end

   assign bus_io.o_grant = grant_q;
   assign bus_io.o_done  = done_q;
   assign bus_io.o_busy  = busy_q;
   assign bus_io.o_pulse = pulse_q;
endmodule

// File: tb/tb_pulse_sched.sv
// Directed bench for pulse_sched: reset, single burst, zero count, round-robin,
// reset mid-burst and request drop mid-burst.
module tb_pulse_sched;
   localparam int unsigned NREQ  = 4;
   localparam int unsigned CNT_W = 8;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   int unsigned vectors     = 0;
   int unsigned miscompares = 0;

   pulse_sched_if #(.NREQ(NREQ), .CNT_W(CNT_W)) bus ();

   pulse_sched #(
      .NREQ    (NREQ),
      .CNT_W   (CNT_W),
      .HIGH_CYC(4),
      .LOW_CYC (4)
   ) dut (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .bus_io (bus)
   );

   always #10 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected vector layout: {grant[3:0], done[3:0], busy, pulse}
   task automatic chk(input string tag, input logic [9:0] exp);
      logic [9:0] obs;
      obs = {bus.o_grant, bus.o_done, bus.o_busy, bus.o_pulse};
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed grant/done/busy/pulse=%b expected %b", tag, obs, exp);
      end
   endtask

   function automatic logic [9:0] ex(input logic [3:0] g, input logic [3:0] d,
                                     input logic b, input logic p);
      return {g, d, b, p};
   endfunction

   task automatic set_count(input int k, input int v);
      bus.i_count[k*CNT_W +: CNT_W] = CNT_W'(v);
   endtask

   // Burst waveform for cycle c (1-based) of an n-pulse burst with 4/4 timing.
   function automatic logic [9:0] burst_exp(input logic [3:0] g, input int c, input int n);
      logic p;
      p = (c <= 8 * n - 4) && (((c - 1) / 4) % 2 == 0);
      return ex(g, (c == 8 * n - 3) ? g : 4'b0000, 1'b1, p);
   endfunction

   initial begin
      bus.i_req   = 4'b1111;
      bus.i_count = '0;
      set_count(0, 1);
      set_count(1, 1);
      set_count(2, 1);
      set_count(3, 1);

      // Reset held with all requests pending
      for (int i = 0; i < 6; i++) begin
         tick();
         chk($sformatf("reset_hold%0d", i), ex(4'b0000, 4'b0000, 1'b0, 1'b0));
      end
      rst_n = 1'b1;
      tick();
      chk("post_reset_grant", ex(4'b0001, 4'b0000, 1'b1, 1'b1));
      bus.i_req = 4'b0000;
      for (int c = 2; c <= 5; c++) begin
         tick();
         chk($sformatf("post_reset_burst c%0d", c), burst_exp(4'b0001, c, 1));
      end
      tick();
      chk("post_reset_idle", ex(4'b0000, 4'b0000, 1'b0, 1'b0));

      // Single 3-pulse burst: 21 busy cycles
      set_count(0, 3);
      bus.i_req = 4'b0001;
      for (int c = 1; c <= 21; c++) begin
         tick();
         if (c == 1) bus.i_req = 4'b0000;
         chk($sformatf("single c%0d", c), burst_exp(4'b0001, c, 3));
      end
      tick();
      chk("single_idle", ex(4'b0000, 4'b0000, 1'b0, 1'b0));

      // Zero count: grant and done together for a single busy cycle
      set_count(3, 0);
      bus.i_req = 4'b1000;
      tick();
      chk("zero_cnt", ex(4'b1000, 4'b1000, 1'b1, 1'b0));
      bus.i_req = 4'b0000;
      tick();
      chk("zero_cnt_idle", ex(4'b0000, 4'b0000, 1'b0, 1'b0));

      // Round-robin between 0 and 2, each count 1: 5 busy + 1 idle per burst
      set_count(0, 1);
      set_count(2, 1);
      bus.i_req = 4'b0101;
      for (int b = 0; b < 4; b++) begin
         for (int c = 1; c <= 6; c++) begin
            tick();
            if (c <= 5)
               chk($sformatf("rr b%0d c%0d", b, c),
                   burst_exp((b % 2 == 0) ? 4'b0001 : 4'b0100, c, 1));
            else
               chk($sformatf("rr b%0d gap", b), ex(4'b0000, 4'b0000, 1'b0, 1'b0));
         end
      end
      bus.i_req = 4'b0000;
      tick();
      chk("rr_end_idle", ex(4'b0000, 4'b0000, 1'b0, 1'b0));

      // Reset during the 2nd HIGH phase of a 5-pulse burst
      set_count(1, 5);
      bus.i_req = 4'b0010;
      for (int c = 1; c <= 10; c++) begin
         tick();
         if (c == 1) bus.i_req = 4'b0000;
         chk($sformatf("pre_abort c%0d", c), burst_exp(4'b0010, c, 5));
      end
      rst_n = 1'b0;
      tick();
      chk("abort_reset", ex(4'b0000, 4'b0000, 1'b0, 1'b0));
      rst_n     = 1'b1;
      bus.i_req = 4'b0011;
      set_count(0, 1);
      tick();
      chk("abort_regrant", ex(4'b0001, 4'b0000, 1'b1, 1'b1));
      bus.i_req = 4'b0000;
      for (int c = 2; c <= 5; c++) begin
         tick();
         chk($sformatf("abort_burst c%0d", c), burst_exp(4'b0001, c, 1));
      end
      tick();
      chk("abort_idle", ex(4'b0000, 4'b0000, 1'b0, 1'b0));

      // Requester 2 drops its request and count after the first pulse
      set_count(2, 4);
      bus.i_req = 4'b0100;
      for (int c = 1; c <= 29; c++) begin
         tick();
         if (c == 4) begin
            bus.i_req = 4'b0000;
            set_count(2, 1);
         end
         chk($sformatf("drop c%0d", c), burst_exp(4'b0100, c, 4));
      end
      tick();
      chk("drop_idle", ex(4'b0000, 4'b0000, 1'b0, 1'b0));
      tick();
      chk("drop_no_regrant", ex(4'b0000, 4'b0000, 1'b0, 1'b0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
